// File: rtl/key_scan_pkg.sv
// -----------------------------------------------------------------------------
// key_scan_pkg
// Shared definitions for the keypad scanner and its consumers.
//   KEY_NONE          : code used for "no key" (scan result and initial key_value)
//   KEY_* operators   : operator key codes used by the calculator datapath
//   scan_state_e      : debounce FSM state encoding
//   min_code()        : smaller of two key codes (KEY_NONE loses to any real key)
//   is_operator()     : 1 when a code is one of the operator keys
// -----------------------------------------------------------------------------
package key_scan_pkg;

    localparam logic [4:0] KEY_NONE  = 5'd31;

    localparam logic [4:0] KEY_ADD   = 5'd3;
    localparam logic [4:0] KEY_MINUS = 5'd7;
    localparam logic [4:0] KEY_MUL   = 5'd11;
    localparam logic [4:0] KEY_RESET = 5'd12;
    localparam logic [4:0] KEY_EQUAL = 5'd14;
    localparam logic [4:0] KEY_DIV   = 5'd15;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } scan_state_e;

    function automatic logic [4:0] min_code(input logic [4:0] a, input logic [4:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic is_operator(input logic [4:0] code);
        return (code == KEY_ADD)   || (code == KEY_MINUS) || (code == KEY_MUL) ||
               (code == KEY_RESET) || (code == KEY_EQUAL) || (code == KEY_DIV);
    endfunction

endpackage

// File: rtl/key_scan_sync2.sv
// -----------------------------------------------------------------------------
// key_scan_sync2
// Width-parameterised two-flop synchronizer for asynchronous level inputs.
//   clk    in          sampling clock
//   rst    in          synchronous reset, active-high (flops load RST_VAL)
//   d_i    in  WIDTH   asynchronous input
//   q_o    out WIDTH   synchronized output (two clk of latency)
// -----------------------------------------------------------------------------
module key_scan_sync2 #(
    parameter int              WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_scan.sv
// -----------------------------------------------------------------------------
// key_scan
// 4x4 matrix keypad scanner with debounce. Walks a single low column across
// the keypad, samples the rows, reduces each full scan to one code (lowest
// pressed key wins) and debounces presses and releases over whole scans.
// One strobe per physical press, no auto-repeat.
//   clk        in   1  system clock
//   rst        in   1  synchronous reset, active-high
//   row_in     in   4  keypad rows, active-low, asynchronous to clk
//   col_out    out  4  column drive, exactly one bit low
//   key_value  out  5  last accepted key code (31 until the first press)
//   flag       out  1  one-cycle pulse when key_value takes a new press
// -----------------------------------------------------------------------------
module key_scan
    import key_scan_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV       = 16'd50000,
    parameter logic [3:0]  DEBOUNCE_SCANS = 4'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [4:0] key_value,
    output logic       flag
);

    // ---------------------------------------------------------------- rows
    logic [3:0] row_sync;

    key_scan_sync2 #(
        .WIDTH   (4),
        .RST_VAL (4'hF)
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d_i (row_in),
        .q_o (row_sync)
    );

    // ------------------------------------------------- divider and columns
    logic [15:0] div_q, div_d;
    logic [1:0]  col_q, col_d;
    logic        tick;

    assign tick = (div_q == (SCAN_DIV - 16'd1));

    always_comb begin
        div_d = tick ? 16'd0 : (div_q + 16'd1);
        col_d = tick ? (col_q + 2'd1) : col_q;
    end

    assign col_out = ~(4'b0001 << col_q);

    // ----------------------------------------------------- priority encode
    // Within one column the lowest row gives the lowest code, and across the
    // scan a running minimum keeps the lowest code seen so far.
    logic [4:0] row_code [4];
    logic [4:0] col_code;
    logic [4:0] acc_q, acc_d;
    logic [4:0] merged_code;
    logic       scan_done;

    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        assign row_code[gi] = row_sync[gi] ? KEY_NONE : {1'b0, 2'(gi), col_q};
    end

    always_comb begin
        col_code    = min_code(min_code(row_code[0], row_code[1]),
                               min_code(row_code[2], row_code[3]));
        // Column 0 opens a new scan, so the previous scan's result is dropped.
        merged_code = min_code((col_q == 2'd0) ? KEY_NONE : acc_q, col_code);
        acc_d       = tick ? merged_code : acc_q;
        scan_done   = tick && (col_q == 2'd3);
    end

    // ------------------------------------------------------- debounce FSM
    scan_state_e state_q, state_d;
    logic [4:0]  cand_q, cand_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  cnt_inc;
    logic [4:0]  key_value_q, key_value_d;
    logic        flag_q, flag_d;

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_value_d = key_value_q;
        flag_d      = 1'b0;
        cnt_inc     = cnt_q + 4'd1;

        if (scan_done) begin
            case (state_q)
                ST_IDLE: begin
                    if (merged_code != KEY_NONE) begin
                        state_d = ST_DEBOUNCE;
                        cand_d  = merged_code;
                        cnt_d   = 4'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (merged_code == KEY_NONE) begin
                        state_d = ST_IDLE;
                    end else if (merged_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEBOUNCE_SCANS) begin
                            state_d     = ST_HELD;
                            key_value_d = cand_q;
                            flag_d      = 1'b1;
                        end
                    end else begin
                        // A different key restarts the count on the new code.
                        cand_d = merged_code;
                        cnt_d  = 4'd1;
                    end
                end
                ST_HELD: begin
                    // Key changes while held are ignored; only a clear scan
                    // starts release debouncing.
                    if (merged_code == KEY_NONE) begin
                        state_d = ST_RELEASE;
                        cnt_d   = 4'd1;
                    end
                end
                ST_RELEASE: begin
                    if (merged_code == KEY_NONE) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEBOUNCE_SCANS) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_HELD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ----------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q       <= 16'd0;
            col_q       <= 2'd0;
            acc_q       <= KEY_NONE;
            state_q     <= ST_IDLE;
            cand_q      <= KEY_NONE;
            cnt_q       <= 4'd0;
            key_value_q <= KEY_NONE;
            flag_q      <= 1'b0;
        end else begin
            div_q       <= div_d;
            col_q       <= col_d;
            acc_q       <= acc_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_value_q <= key_value_d;
            flag_q      <= flag_d;
        end
    end

    assign key_value = key_value_q;
    assign flag      = flag_q;

endmodule
